// File: rtl/bundler_multilane.sv
// bundler_multilane
//   Majority bundler for hypervectors. Bundles up to NUM_HVS input
//   hypervectors into a single hypervector by per-dimension majority vote,
//   evaluating LANES dimensions per clock. A per-input mask selects which
//   vectors take part, and ties are resolved according to TIE_MODE.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request a bundle (accepted only while ready=1)
//   abort        cancel a bundle in progress
//   hv_mask      participation mask, sampled on an accepted start
//   hv_array     input hypervectors, held stable from start until done
//   ready        idle and able to accept start
//   busy         a bundle is being computed
//   done         one-cycle pulse, hv_out is complete
//   active_count popcount of the latched mask
//   hv_out       bundled hypervector
module bundler_multilane #(
  parameter int DIMENSIONS = 10000,
  parameter int NUM_HVS    = 17,
  parameter int LANES      = 8,
  parameter int TIE_MODE   = 0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic                                    abort,
  input  logic [NUM_HVS-1:0]                      hv_mask,
  input  logic [NUM_HVS-1:0][DIMENSIONS-1:0]      hv_array,
  output logic                                    ready,
  output logic                                    busy,
  output logic                                    done,
  output logic [$clog2(NUM_HVS):0]                active_count,
  output logic [DIMENSIONS-1:0]                   hv_out
);

  localparam int CNT_W = $clog2(NUM_HVS) + 1;
  localparam int IDX_W = (NUM_HVS > 1) ? $clog2(NUM_HVS) : 1;
  localparam int DIX_W = (DIMENSIONS > 1) ? $clog2(DIMENSIONS) : 1;
  localparam int PTR_W = $clog2(DIMENSIONS + LANES) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state;
  logic [NUM_HVS-1:0] mask_q;
  logic [IDX_W-1:0]   first_idx;
  logic [IDX_W-1:0]   last_idx;
  logic [PTR_W-1:0]   ptr;

  logic [CNT_W-1:0]   mask_pop;
  logic [IDX_W-1:0]   mask_first;
  logic [IDX_W-1:0]   mask_last;

  logic [LANES-1:0]   lane_valid;
  logic [LANES-1:0]   lane_bit;
  logic [DIX_W-1:0]   lane_d [LANES];
  logic               last_chunk;

  // Majority decision for one dimension d. dn is the neighbouring dimension
  // (d+1, wrapping to 0) used by the XOR tie-break. The vote is compared as
  // 2*ones against active_count so no fractional threshold is needed.
  function automatic logic vote_bit(input logic [DIX_W-1:0] d,
                                    input logic [DIX_W-1:0] dn);
    logic [CNT_W-1:0] ones;
    logic [CNT_W:0]   twice;
    logic             tie_bit;
    ones = '0;
    for (int i = 0; i < NUM_HVS; i++) begin
      ones = ones + CNT_W'(mask_q[i] & hv_array[i][d]);
    end
    twice = {ones, 1'b0};
    if (TIE_MODE == 1) begin
      tie_bit = 1'b0;
    end else if (TIE_MODE == 2) begin
      tie_bit = 1'b1;
    end else begin
      tie_bit = hv_array[first_idx][dn] ^ hv_array[last_idx][dn];
    end
    if (twice > {1'b0, active_count}) begin
      return 1'b1;
    end else if (twice < {1'b0, active_count}) begin
      return 1'b0;
    end else begin
      return tie_bit;
    end
  endfunction

  // Decode the incoming mask: number of participants plus the lowest and
  // highest participating index. An empty mask leaves both indices at 0,
  // which makes the XOR tie-break collapse to 0.
  always_comb begin
    mask_pop   = '0;
    mask_first = '0;
    mask_last  = '0;
    for (int i = NUM_HVS - 1; i >= 0; i--) begin
      if (hv_mask[i]) mask_first = IDX_W'(i);
    end
    for (int i = 0; i < NUM_HVS; i++) begin
      if (hv_mask[i]) begin
        mask_pop  = mask_pop + CNT_W'(1);
        mask_last = IDX_W'(i);
      end
    end
  end

  // Evaluate the LANES dimensions of the current chunk. Lanes that fall past
  // the last dimension in a partial final chunk are flagged invalid and
  // never written.
  always_comb begin
    lane_valid = '0;
    lane_bit   = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_d[k] = '0;
      if (int'(ptr) + k < DIMENSIONS) begin
        lane_valid[k] = 1'b1;
        lane_d[k]     = DIX_W'(int'(ptr) + k);
        lane_bit[k]   = vote_bit(lane_d[k],
                                 (int'(ptr) + k == DIMENSIONS - 1) ? '0
                                 : DIX_W'(int'(ptr) + k + 1));
      end
    end
  end

  assign last_chunk = (int'(ptr) + LANES >= DIMENSIONS);

  // Control FSM. ready/busy/done are registered; the done pulse is emitted on
  // the edge after the final chunk is written, and ready only returns on the
  // edge after that, so a start during the done cycle is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      ready        <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      active_count <= '0;
      hv_out       <= '0;
      ptr          <= '0;
      mask_q       <= '0;
      first_idx    <= '0;
      last_idx     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!ready) begin
            ready <= 1'b1;
          end else if (start) begin
            mask_q       <= hv_mask;
            active_count <= mask_pop;
            first_idx    <= mask_first;
            last_idx     <= mask_last;
            ptr          <= '0;
            ready        <= 1'b0;
            busy         <= 1'b1;
            state        <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            ready <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            for (int k = 0; k < LANES; k++) begin
              if (lane_valid[k]) hv_out[lane_d[k]] <= lane_bit[k];
            end
            ptr <= ptr + PTR_W'(LANES);
            if (last_chunk) state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bundler_multilane.md
Name: bundler_multilane

Overview:
- Parametrised majority bundler for hypervectors. It bundles up to NUM_HVS input hypervectors into one output hypervector by per-dimension majority vote.
- Processes LANES dimensions per clock instead of one. Adds a per-input active mask (variable bundle size), a selectable tie-break mode, and a start/done handshake with abort.
- Sits after encoders and spatial/temporal binders. Feeds the associative-memory and classifier stages.

Parameters:
DIMENSIONS, 10000, hypervector width in bits
NUM_HVS, 17, maximum number of input hypervectors
LANES, 8, dimensions evaluated per clock (1..DIMENSIONS)
TIE_MODE, 0, tie-break: 0 = XOR of first/last active HV at dimension d+1 (wraps to 0); 1 = force 0; 2 = force 1

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request a bundle; accepted only when ready=1
abort  input  1  cancel an operation in progress
hv_mask  input  NUM_HVS  bit i=1 means hv_array[i] participates; sampled at start
hv_array  input  NUM_HVS x DIMENSIONS  input hypervectors; must be held stable from accepted start until done
ready  output  1  idle, can accept start
busy  output  1  computing
done  output  1  one-cycle pulse; hv_out complete
active_count  output  clog2(NUM_HVS)+1  popcount of the latched mask
hv_out  output  DIMENSIONS  bundled hypervector

Behaviour:
- Reset (rst=1 at clk edge), regardless of state:
  - state=IDLE, ready=1, busy=0, done=0, active_count=0, hv_out=0.
  - Internal dimension pointer=0, latched mask=0.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 latches hv_mask and computes active_count.
  - Latches first_idx and last_idx, the lowest and highest set mask bits (both 0 if the mask is 0).
  - Clears the pointer and moves to RUN: ready=0, busy=1 from the next cycle.
- RUN, per cycle, for lanes k=0..LANES-1 and d=ptr+k with d<DIMENSIONS:
  - ones = count of active i with hv_array[i][d]=1.
  - 2*ones > active_count -> hv_out[d]=1.
  - 2*ones < active_count -> hv_out[d]=0.
  - Tie (only possible with even active_count, including 0): resolved per TIE_MODE.
  - TIE_MODE 0: hv_out[d] = hv_array[first_idx][d'] ^ hv_array[last_idx][d'], where d' = d+1, or 0 when d = DIMENSIONS-1.
  - Lanes with d >= DIMENSIONS in the final partial chunk write nothing.
  - ptr advances by LANES each cycle.
- RUN lasts C = ceil(DIMENSIONS/LANES) cycles, then the block enters DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE with ready=1.
- Latency: start accepted at edge 0; done high during the cycle after edge C+1 (C cycles RUN, 1 cycle DONE).
- hv_out is written in place during RUN and is valid from done until the next accepted start. It is not cleared at start; bits not yet rewritten hold old data.
- mask=0: active_count=0, so every dimension is a tie.
  - TIE_MODE 0 gives hv_array[0]^hv_array[0] = 0. Modes 1 and 2 give all 0 and all 1 respectively.
  - Normal latency applies.
- mask with one bit set: hv_out = that vector, no ties.
- Masked-off vectors never influence the result, tie-break included.
- start while busy or in DONE: ignored, not queued.
- abort in RUN: returns to IDLE next cycle, no done pulse. hv_out is partially updated and undefined for use.
- abort in IDLE/DONE: no effect.
- abort and start in the same IDLE cycle: start wins.
- Count logic sized so ones up to NUM_HVS never overflows.
- Comparison is exact integer arithmetic (2*ones vs active_count); no real-valued thresholds.

Test Plan:
1. NUM_HVS=3, D=8, LANES=4, mask=111, hv0=0xF0, hv1=0xCC, hv2=0xAA, start -> hv_out=0xE8, active_count=3, done pulses once in the cycle after edge 3, ready back 1 cycle later.
2. NUM_HVS=4, D=8, LANES=4, TIE_MODE=0, mask=1111, hv0=0xF0, hv1=0x0F, hv2=0xFF, hv3=0x00 -> all dimensions tie, hv_out=0x78 (wrap checked at bit 7). Repeat with TIE_MODE=1 -> 0x00; TIE_MODE=2 -> 0xFF.
3. Test 1 vectors plus hv3=0xFF, NUM_HVS=4, mask=0111 -> hv_out=0xE8, active_count=3 (masked vector ignored). mask=0000 with TIE_MODE=0 -> hv_out=0x00 at normal latency.
4. D=10, LANES=4 (partial chunk), mask with one bit set, vector 0x2A5 -> hv_out=0x2A5. RUN lasts 3 cycles; lanes beyond dimension 9 are not written.
5. Pulse start again on every RUN cycle -> ignored, single done. Assert abort at RUN cycle 1 -> IDLE next cycle, no done, ready=1. A new start then completes with the correct result.
6. Default parameters, 17 random vectors, all masked active, compared against a golden model. Assert rst mid-RUN -> all outputs at reset values next cycle; a subsequent start produces the golden result.
